// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared types, widths and default timing for player_input_ctrl
package duck_pkg;

  // Per-direction move sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } move_state_e;

  // Ammunition counter width; rounds hold at most 3 shots
  localparam int SHOTS_W = 2;

  // Default timing at a 50 MHz system clock
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_RATE     = 2500000;
  localparam int DEF_COOLDOWN_CYCLES = 5000000;
  localparam int DEF_SHOTS_PER_ROUND = 3;

  // Width of an unsigned counter that must hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_input_ctrl_if.sv
// rtl/player_input_ctrl_if.sv - button pins in, game-core pulses out
interface player_input_ctrl_if;
  import duck_pkg::*;

  logic               izq;
  logic               der;
  logic               fire;
  logic               reload;
  logic               move_left;
  logic               move_right;
  logic               fire_pulse;
  logic               dry_fire;
  logic [SHOTS_W-1:0] shots_left;
  logic               cooling;

  // Board pins and game core side
  modport master (
    output izq, der, fire, reload,
    input  move_left, move_right, fire_pulse, dry_fire, shots_left, cooling
  );

  // Conditioning block side
  modport slave (
    input  izq, der, fire, reload,
    output move_left, move_right, fire_pulse, dry_fire, shots_left, cooling
  );

endinterface

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchroniser plus stable-count debounce for one button
module debouncer
  import duck_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int             CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  // The level flips on the edge where the count would reach DEBOUNCE_CYCLES
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles of disagreement; any agreement clears the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Synchroniser chain, debounce counter and accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - button conditioning to move/shot pulses; AUTO_REPEAT_EN adds held-button auto-repeat
module player_input_ctrl
  import duck_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int SHOTS_PER_ROUND = DEF_SHOTS_PER_ROUND
) (
  input logic                clk,
  input logic                reset,
  player_input_ctrl_if.slave bus
);

  localparam int               CD_W       = cnt_width(COOLDOWN_CYCLES);
  localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN_CYCLES);
  localparam logic [CD_W-1:0]  CD_ONE     = CD_W'(1);
  localparam logic [SHOTS_W-1:0] SHOTS_INIT = SHOTS_W'(SHOTS_PER_ROUND);
  localparam logic [SHOTS_W-1:0] SHOTS_ONE  = SHOTS_W'(1);

  logic deb_izq;
  logic deb_der;
  logic deb_fire;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_izq (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (bus.izq),
    .level_o (deb_izq)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_der (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (bus.der),
    .level_o (deb_der)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (bus.fire),
    .level_o (deb_fire)
  );

  // Index 0 is left, index 1 is right; both held cancels movement
  logic [1:0] act;
  logic [1:0] act_prev_q;
  logic [1:0] mv_pulse_d;
  logic [1:0] mv_pulse_q;

  assign act = {deb_der & ~deb_izq, deb_izq & ~deb_der};

`ifdef AUTO_REPEAT_EN
  localparam int              MV_W  = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [MV_W-1:0] RD_V  = MV_W'(REPEAT_DELAY);
  localparam logic [MV_W-1:0] RR_V  = MV_W'(REPEAT_RATE);
  localparam logic [MV_W-1:0] MV_ONE = MV_W'(1);

  move_state_e     mv_state_q [2];
  move_state_e     mv_state_d [2];
  logic [MV_W-1:0] mv_cnt_q   [2];
  logic [MV_W-1:0] mv_cnt_d   [2];

  // Per-direction step sequencer: press edge, first repeat after the delay, then steady rate
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mv_state_d[i] = mv_state_q[i];
      mv_cnt_d[i]   = mv_cnt_q[i];
      mv_pulse_d[i] = 1'b0;
      if (!act[i]) begin
        mv_state_d[i] = IDLE;
        mv_cnt_d[i]   = '0;
      end else begin
        case (mv_state_q[i])
          IDLE: begin
            if (!act_prev_q[i]) begin
              mv_pulse_d[i] = 1'b1;
              mv_cnt_d[i]   = RD_V;
              mv_state_d[i] = DELAY;
            end
          end
          DELAY, REPEAT: begin
            // A count of one means this edge completes the interval
            if (mv_cnt_q[i] <= MV_ONE) begin
              mv_pulse_d[i] = 1'b1;
              mv_cnt_d[i]   = RR_V;
              mv_state_d[i] = REPEAT;
            end else begin
              mv_cnt_d[i] = mv_cnt_q[i] - MV_ONE;
            end
          end
          default: begin
            mv_state_d[i] = IDLE;
            mv_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Sequencer state and repeat timers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mv_state_q[i] <= IDLE;
        mv_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mv_state_q[i] <= mv_state_d[i];
        mv_cnt_q[i]   <= mv_cnt_d[i];
      end
    end
  end
`else
  // Repeat timing has no effect in single-pulse mode
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

  // One step pulse per qualified press
  always_comb begin
    mv_pulse_d = act & ~act_prev_q;
  end
`endif

  logic               fire_prev_q;
  logic               fire_rise;
  logic [SHOTS_W-1:0] shots_q;
  logic [SHOTS_W-1:0] shots_d;
  logic [CD_W-1:0]    cool_q;
  logic [CD_W-1:0]    cool_d;
  logic               fire_pulse_q;
  logic               fire_pulse_d;
  logic               dry_q;
  logic               dry_d;
  logic               cooling_q;
  logic               cooling_d;

  assign fire_rise = deb_fire & ~fire_prev_q;

  // Shot arbitration: reload beats a press, cooldown swallows it, empty magazine dry-fires
  always_comb begin
    shots_d      = shots_q;
    cool_d       = (cool_q != '0) ? (cool_q - CD_ONE) : '0;
    fire_pulse_d = 1'b0;
    dry_d        = 1'b0;
    // Lags the counter by one so cooling starts the cycle after the shot
    cooling_d    = (cool_q != '0);
    if (bus.reload) begin
      shots_d   = SHOTS_INIT;
      cool_d    = '0;
      cooling_d = 1'b0;
    end else if (fire_rise && (cool_q == '0)) begin
      if (shots_q == '0) begin
        dry_d = 1'b1;
      end else begin
        fire_pulse_d = 1'b1;
        shots_d      = shots_q - SHOTS_ONE;
        cool_d       = CD_LOAD;
      end
    end
  end

  // Edge history, ammo, cooldown and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_prev_q   <= '0;
      mv_pulse_q   <= '0;
      fire_prev_q  <= 1'b0;
      shots_q      <= SHOTS_INIT;
      cool_q       <= '0;
      fire_pulse_q <= 1'b0;
      dry_q        <= 1'b0;
      cooling_q    <= 1'b0;
    end else begin
      act_prev_q   <= act;
      mv_pulse_q   <= mv_pulse_d;
      fire_prev_q  <= deb_fire;
      shots_q      <= shots_d;
      cool_q       <= cool_d;
      fire_pulse_q <= fire_pulse_d;
      dry_q        <= dry_d;
      cooling_q    <= cooling_d;
    end
  end

  assign bus.move_left  = mv_pulse_q[0];
  assign bus.move_right = mv_pulse_q[1];
  assign bus.fire_pulse = fire_pulse_q;
  assign bus.dry_fire   = dry_q;
  assign bus.shots_left = shots_q;
  assign bus.cooling    = cooling_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb/tb_player_input_ctrl.sv - scoreboard bench for player_input_ctrl
module tb_player_input_ctrl;

  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int C   = 5;
  localparam int LAT = D + 3;

  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_FIRE  = 3;
  localparam int K_DRY   = 4;

  typedef struct {
    int kind;
    int cyc;
    int shots;
  } sb_item_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_fire2 = 0;
  int   n_dry2 = 0;
  sb_item_t sb[$];

  player_input_ctrl_if bus ();
  player_input_ctrl_if bus2 ();

  player_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .COOLDOWN_CYCLES (C),
    .SHOTS_PER_ROUND (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Long cooldown instance: lets a debounced press land inside the cooldown window
  player_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .COOLDOWN_CYCLES (12),
    .SHOTS_PER_ROUND (3)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_push(input int kind, input int at, input int shots);
    sb_item_t it;
    it.kind  = kind;
    it.cyc   = at;
    it.shots = shots;
    sb.push_back(it);
  endtask

  task automatic sb_pop(input int kind);
    sb_item_t it;
    if (sb.size() == 0) begin
      check_eq("unexpected_pulse", kind, 0);
    end else begin
      it = sb.pop_front();
      check_eq("ev_kind", kind, it.kind);
      check_eq("ev_cycle", cyc, it.cyc);
      if (kind == K_FIRE) check_eq("ev_shots", int'(bus.shots_left), it.shots);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.move_left)  sb_pop(K_LEFT);
      if (bus.move_right) sb_pop(K_RIGHT);
      if (bus.fire_pulse) sb_pop(K_FIRE);
      if (bus.dry_fire)   sb_pop(K_DRY);
      if (bus2.fire_pulse) n_fire2 <= n_fire2 + 1;
      if (bus2.dry_fire)   n_dry2 <= n_dry2 + 1;
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press_fire(input int kind, input int shots);
    int p;
    p = cyc;
    bus.fire = 1'b1;
    sb_push(kind, p + LAT, shots);
    step_to(p + 8);
    bus.fire = 1'b0;
    step_to(p + 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, f, rel, a, c, p, r;
    reset = 1'b0;
    bus.izq = 1'b0;  bus.der = 1'b0;  bus.fire = 1'b0;  bus.reload = 1'b0;
    bus2.izq = 1'b0; bus2.der = 1'b0; bus2.fire = 1'b0; bus2.reload = 1'b0;

    // Reset state
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_shots", int'(bus.shots_left), 3);
    check_eq("rst_cooling", int'(bus.cooling), 0);
    reset = 1'b1;
    step_to(cyc + 1);
    check_eq("post_rst_left", int'(bus.move_left), 0);
    check_eq("post_rst_right", int'(bus.move_right), 0);
    check_eq("post_rst_fire", int'(bus.fire_pulse), 0);
    check_eq("post_rst_dry", int'(bus.dry_fire), 0);
    check_eq("post_rst_shots", int'(bus.shots_left), 3);

    // Bouncing left press, then held: one step plus any auto-repeats
    step_to(cyc + 2);
    bus.izq = 1'b1;
    step_to(cyc + 2);
    bus.izq = 1'b0;
    step_to(cyc + 2);
    bus.izq = 1'b1;
    t   = cyc;
    f   = t + LAT;
    rel = f + 18;
    sb_push(K_LEFT, f, -1);
`ifdef AUTO_REPEAT_EN
    for (int e = f + RD; e <= rel + 2 + D; e += RR) sb_push(K_LEFT, e, -1);
`endif
    step_to(rel);
    bus.izq = 1'b0;
    step_to(rel + 15);

    // Conflict: der cancels left; releasing izq starts right from idle
    a = cyc;
    bus.izq = 1'b1;
    sb_push(K_LEFT, a + LAT, -1);
    step_to(a + 9);
    bus.der = 1'b1;
    step_to(a + 20);
    c = cyc;
    bus.izq = 1'b0;
    sb_push(K_RIGHT, c + LAT, -1);
    step_to(c + 10);
    bus.der = 1'b0;
    step_to(c + 25);

    // First shot with cooldown window observed
    p = cyc;
    bus.fire = 1'b1;
    sb_push(K_FIRE, p + LAT, 2);
    step_to(p + 8);
    bus.fire = 1'b0;
    at_neg(p + 8);
    check_eq("cool_start", int'(bus.cooling), 1);
    at_neg(p + 7 + C);
    check_eq("cool_last", int'(bus.cooling), 1);
    at_neg(p + 8 + C);
    check_eq("cool_end", int'(bus.cooling), 0);
    step_to(p + 20);
    press_fire(K_FIRE, 1);
    press_fire(K_FIRE, 0);
    press_fire(K_DRY, -1);

    // Reload refills the magazine
    r = cyc;
    bus.reload = 1'b1;
    step_to(r + 1);
    bus.reload = 1'b0;
    at_neg(r + 1);
    check_eq("reload_shots", int'(bus.shots_left), 3);
    step_to(r + 5);
    press_fire(K_FIRE, 2);
    press_fire(K_FIRE, 1);

    // Reload coincident with a debounced fire edge
    p = cyc;
    bus.fire = 1'b1;
    step_to(p + 6);
    bus.reload = 1'b1;
    step_to(p + 7);
    bus.reload = 1'b0;
    at_neg(p + 7);
    check_eq("coin_shots", int'(bus.shots_left), 3);
    check_eq("coin_fire", int'(bus.fire_pulse), 0);
    check_eq("coin_dry", int'(bus.dry_fire), 0);
    check_eq("coin_cooling", int'(bus.cooling), 0);
    step_to(p + 8);
    bus.fire = 1'b0;
    at_neg(p + 8);
    check_eq("coin_cooling_next", int'(bus.cooling), 0);
    step_to(p + 20);
    press_fire(K_FIRE, 2);

    // Reset mid-cooldown with izq held through reset release
    p = cyc;
    bus.fire = 1'b1;
    sb_push(K_FIRE, p + LAT, 1);
    step_to(p + 8);
    bus.fire = 1'b0;
    bus.izq = 1'b1;
    at_neg(p + 9);
    check_eq("pre_rst_cooling", int'(bus.cooling), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_shots", int'(bus.shots_left), 3);
    check_eq("async_rst_cooling", int'(bus.cooling), 0);
    step_to(cyc + 2);
    reset = 1'b1;
    r = cyc;
    sb_push(K_LEFT, r + LAT, -1);
    step_to(r + 8);
    bus.izq = 1'b0;
    step_to(r + 25);

    // Press landing inside a long cooldown is ignored
    p = cyc;
    bus2.fire = 1'b1;
    step_to(p + 4);
    bus2.fire = 1'b0;
    step_to(p + 8);
    bus2.fire = 1'b1;
    step_to(p + 12);
    bus2.fire = 1'b0;
    at_neg(p + 15);
    check_eq("cd2_cooling", int'(bus2.cooling), 1);
    step_to(p + 30);
    check_eq("cd2_shots", n_fire2, 1);
    check_eq("cd2_dry", n_dry2, 0);
    check_eq("cd2_ammo", int'(bus2.shots_left), 2);

    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
